imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Writer side of the instruction-memory interface. The CPU core only reads instruction memory; this block fills it at run time from a UART byte stream.
- Receives a framed program image and assembles little-endian 32-bit words.
- Issues one-cycle write strobes to the instruction-memory write port.
- Holds the CPU (cpu_hold_o) while a load is in progress.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, minimum 4
- ADDR_W, 6, instruction-memory word-address width (64 words)
- TIMEOUT_CYC, 2000000, idle cycles allowed between bytes inside a frame

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_i  in  1  UART receive line, asynchronous, idle high
- load_en_i  in  1  loader enable (board switch)
- im_we_o  out  1  instruction-memory write strobe, one cycle per word
- im_addr_o  out  ADDR_W  word address for the write
- im_wdata_o  out  32  write data
- cpu_hold_o  out  1  CPU clock-enable gate; 1 = CPU frozen
- busy_o  out  1  frame in progress
- done_o  out  1  last frame loaded successfully
- err_o  out  1  last frame aborted
- word_cnt_o  out  ADDR_W+1  number of words written in the current or last frame

Behaviour:
- Reset: all outputs 0, FSM in IDLE, receiver in IDLE. Reset mid-frame abandons the frame; no further writes occur.
- rx_i passes through a 2-FF synchronizer before any use.

UART receive (8N1, LSB first):
- Start detect: falling edge, re-checked at half a bit time; if the line is high again, treat as a glitch and return to idle.
- Data bits are sampled every CLKS_PER_BIT cycles at bit centre.
- Stop bit sampled at its centre:
  - 1: byte_valid pulses for one cycle.
  - 0: framing error; byte discarded, fe pulses for one cycle.

Loader FSM: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE / DONE / ERR:
  - On a valid byte 0xA5 with load_en_i=1: go to LEN; cpu_hold_o=1, busy_o=1, done_o=0, err_o=0, word_cnt_o=0.
  - All other bytes are ignored.
- LEN:
  - Byte N = word count. N=0 or N > 2^ADDR_W goes to ERR.
  - Otherwise latch N and go to DATA.
- DATA:
  - Bytes fill the word LSB first (byte0 -> [7:0] ... byte3 -> [31:24]).
  - The cycle after the 4th byte's byte_valid: im_we_o=1 for exactly one cycle, im_addr_o = word index (starting at 0), im_wdata_o = assembled word; word_cnt_o increments in the same cycle.
  - After word N is written: go to CHK (feature enabled) or DONE.
- DONE: cpu_hold_o=0, busy_o=0, done_o=1.
- ERR: err_o=1, busy_o=0, cpu_hold_o stays 1 (memory is partially written).
- Abort to ERR from LEN, DATA or CHK on any of:
  - framing error;
  - load_en_i falling;
  - TIMEOUT_CYC cycles with no byte_valid (counter resets on every byte_valid).
- load_en_i=0 in IDLE: no frame starts; cpu_hold_o=0.
- A framing error outside a frame is ignored.
- im_addr_o and im_wdata_o hold their last values when im_we_o=0.
- Simultaneous byte_valid and timeout expiry: the byte wins.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the data, one extra byte is expected: 8-bit sum mod 256 of all 4N data bytes, accumulated in DATA.
  - Match goes to DONE; mismatch goes to ERR.
  - Words are already written either way; the checksum only gates the release of cpu_hold_o.
- Undefined: CHK state and accumulator are absent; DONE is entered the cycle after the last write.

Decomposition:
- Shared package:
  - FSM state encoding;
  - SYNC_BYTE = 8'hA5;
  - the CLKS_PER_BIT derivation function.
- Sub-module uart_rx:
  - contains synchronizer, bit timer and shift register;
  - outputs: byte, byte_valid, fe.
- Top level holds the loader FSM, word assembly, counters and checksum.

Test Plan:
Use CLK_FREQ=1600000, BAUD=100000 (16 clocks/bit), TIMEOUT_CYC=1000, feature defined unless noted.
1. Rx A5 02 13 00 00 00 93 00 10 00 B6
   -> im_we_o pulses twice: addr0=0x00000013, addr1=0x00100093; done_o=1, cpu_hold_o=0, word_cnt_o=2.
2. Same frame with checksum byte 00
   -> both writes occur; err_o=1, done_o=0, cpu_hold_o=1.
3. Bytes 00 FF 5A, then frame from (1)
   -> junk ignored, no writes before A5, same result as (1).
4. A5 00
   -> err_o=1, no writes. Then A5 01 33 00 00 00 33 -> addr0=0x00000033, done_o=1.
5. A5 02 13 00, then stop bit driven 0 on next byte
   -> err_o=1 and no im_we_o pulse. A5 03 then line idle 1000 cycles -> err_o=1 (timeout).
6. rst asserted after 6 data bytes of frame (1)
   -> next cycle all outputs 0, only one write occurred. Full frame (1) afterwards -> loads normally.
   - Rerun (1) with the feature undefined and no B6 byte -> done_o=1 the cycle after the second write.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// rtl/imem_uart_loader_pkg.sv - shared state encodings, sync byte and bit-timing helper
package imem_uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Bit period in clocks; clamped so the half-bit re-check always has room.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        int c;
        c = clk_freq / baud;
        if (c < 4) c = 4;
        return c;
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// rtl/imem_uart_loader_uart_rx.sv - 8N1 UART receiver with input synchronizer
module imem_uart_loader_uart_rx
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       fe
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            sync1, sync2, prev;
    rx_state_t       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            bv_d, fe_d;

    assign rx_byte = shift_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Receiver state, bit timer, shift register and one-cycle result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            fe         <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_valid <= bv_d;
            fe         <= fe_d;
        end
    end

    // Next-state: start re-checked at half bit, data and stop sampled at bit centre.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev && !sync2) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    bv_d  = sync2;
                    fe_d  = !sync2;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART program loader for instruction memory (option: LOADER_CHECKSUM_EN)
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic              load_en_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TW        = $clog2(TIMEOUT_CYC + 1);
    localparam int CW        = ADDR_W + 1;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    logic [7:0]    rx_byte;
    logic          byte_valid, fe;
    ld_state_t     state_q, state_d;
    logic [CW-1:0] len_q;
    logic [1:0]    sel_q;
    logic [23:0]   buf_q;
    logic [TW-1:0] tcnt_q;
    logic          load_en_q;
    logic          in_frame, timeout, abort, start_frame, last_written;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    imem_uart_loader_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_i),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .fe        (fe)
    );

    // Frame events, next-state selection and status decode.
    always_comb begin
        in_frame     = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
        timeout      = (tcnt_q == TW'(TIMEOUT_CYC - 1)) && !byte_valid;
        abort        = in_frame && (fe || (load_en_q && !load_en_i) || timeout);
        start_frame  = !in_frame && byte_valid && (rx_byte == SYNC_BYTE) && load_en_i;
        last_written = im_we_o && (word_cnt_o == len_q);
        state_d      = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_frame) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_valid) begin
                    if (rx_byte == 8'd0 || int'(rx_byte) > MAX_WORDS) state_d = ST_ERR;
                    else                                              state_d = ST_DATA;
                end
            end
            ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (last_written) state_d = ST_CHK;
`else
                if (last_written) state_d = ST_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (byte_valid) state_d = (rx_byte == sum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_ERR;

        busy_o     = in_frame;
        done_o     = (state_q == ST_DONE);
        err_o      = (state_q == ST_ERR);
        cpu_hold_o = in_frame || (state_q == ST_ERR);
    end

    // State register, word assembly, write strobe, counters and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            im_we_o    <= 1'b0;
            im_addr_o  <= '0;
            im_wdata_o <= '0;
            word_cnt_o <= '0;
            len_q      <= '0;
            sel_q      <= '0;
            buf_q      <= '0;
            tcnt_q     <= '0;
            load_en_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            load_en_q <= load_en_i;
            im_we_o   <= 1'b0;
            if (!in_frame || byte_valid) tcnt_q <= '0;
            else                         tcnt_q <= tcnt_q + TW'(1);
            if (start_frame) begin
                word_cnt_o <= '0;
                sel_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end
            if (state_q == ST_LEN && byte_valid) len_q <= CW'(rx_byte);
            if (state_q == ST_DATA && byte_valid && !abort) begin
                sel_q <= sel_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_q <= sum_q + rx_byte;
`endif
                case (sel_q)
                    2'd0: buf_q[7:0]   <= rx_byte;
                    2'd1: buf_q[15:8]  <= rx_byte;
                    2'd2: buf_q[23:16] <= rx_byte;
                    default: begin
                        im_we_o    <= 1'b1;
                        im_addr_o  <= word_cnt_o[ADDR_W-1:0];
                        im_wdata_o <= {rx_byte, buf_q};
                        word_cnt_o <= word_cnt_o + CW'(1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - table-driven scoreboard bench for imem_uart_loader
module tb_imem_uart_loader;

    localparam int CPB = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        load_en = 1'b0;
    logic        im_we;
    logic [5:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold, busy, done, err;
    logic [6:0]  word_cnt;

    imem_uart_loader #(
        .CLK_FREQ   (1600000),
        .BAUD       (100000),
        .ADDR_W     (6),
        .TIMEOUT_CYC(1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx),
        .load_en_i (load_en),
        .im_we_o   (im_we),
        .im_addr_o (im_addr),
        .im_wdata_o(im_wdata),
        .cpu_hold_o(cpu_hold),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .word_cnt_o(word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [127:0] bytes;
        int           nb;
        int           nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic         done;
        logic         err;
        logic         hold;
        int           wcnt;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_we_cyc = -1;
    int   done_rise_cyc = -1;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && im_we) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 64'(im_addr), 64'(e.addr));
                check("write_data", 64'(im_wdata), 64'(e.data));
            end
        end
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (stop ? 2 : CPB) @(negedge clk);
    endtask

    task automatic send_seq(input logic [127:0] bytes, input int nb);
        for (int i = 0; i < nb; i++) send_byte(bytes[8*(nb-1-i) +: 8], 1'b1);
    endtask

    function automatic vec_t mkv(input logic [127:0] bytes, input int nb, input int nw,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic dn, input logic er, input logic hd, input int wc);
        vec_t v;
        v.bytes = bytes; v.nb = nb; v.nw = nw; v.w0 = w0; v.w1 = w1;
        v.done = dn; v.err = er; v.hold = hd; v.wcnt = wc;
        return v;
    endfunction

    task automatic push_frame1();
        exp_q.push_back('{addr: 6'd0, data: 32'h00000013});
        exp_q.push_back('{addr: 6'd1, data: 32'h00100093});
    endtask

    task automatic send_frame1();
        if (CHK_EN) send_seq(128'hA5021300000093001000B6, 11);
        else        send_seq(128'hA502130000009300100000 >> 8, 10);
    endtask

    initial begin
        // Frame 1, bad checksum (or a one-word frame), junk + frame 1, N=0, one word, N=65.
        if (CHK_EN) begin
            vecs[0] = mkv(128'hA5021300000093001000B6, 11, 2, 32'h13, 32'h100093, 1, 0, 0, 2);
            vecs[1] = mkv(128'hA50213000000930010000, 11, 2, 32'h13, 32'h100093, 0, 1, 1, 2);
            vecs[1].bytes = 128'hA502130000009300100000;
            vecs[2] = mkv(128'h00FF5AA5021300000093001000B6, 14, 2, 32'h13, 32'h100093, 1, 0, 0, 2);
            vecs[4] = mkv(128'hA5013300000033, 7, 1, 32'h33, 32'h0, 1, 0, 0, 1);
        end else begin
            vecs[0] = mkv(128'hA5021300000093001000, 10, 2, 32'h13, 32'h100093, 1, 0, 0, 2);
            vecs[1] = mkv(128'hA50144332211, 6, 1, 32'h11223344, 32'h0, 1, 0, 0, 1);
            vecs[2] = mkv(128'h00FF5AA5021300000093001000, 13, 2, 32'h13, 32'h100093, 1, 0, 0, 2);
            vecs[4] = mkv(128'hA50133000000, 6, 1, 32'h33, 32'h0, 1, 0, 0, 1);
        end
        vecs[3] = mkv(128'hA500, 2, 0, 32'h0, 32'h0, 0, 1, 1, 0);
        vecs[5] = mkv(128'hA541, 2, 0, 32'h0, 32'h0, 0, 1, 1, 0);

        repeat (4) @(negedge clk);
        check("reset_we", 64'(im_we), 64'(0));
        check("reset_addr", 64'(im_addr), 64'(0));
        check("reset_wdata", 64'(im_wdata), 64'(0));
        check("reset_status", 64'({cpu_hold, busy, done, err}), 64'(0));
        check("reset_wcnt", 64'(word_cnt), 64'(0));
        rst = 1'b0;

        // Loader disabled: a valid-looking frame must not start.
        send_seq(128'hA50133000000, 6);
        check("disabled_status", 64'({cpu_hold, busy, done, err}), 64'(0));

        load_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].nw > 0) exp_q.push_back('{addr: 6'd0, data: vecs[v].w0});
            if (vecs[v].nw > 1) exp_q.push_back('{addr: 6'd1, data: vecs[v].w1});
            send_seq(vecs[v].bytes, vecs[v].nb);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_done", v), 64'(done), 64'(vecs[v].done));
            check($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].err));
            check($sformatf("vec%0d_hold", v), 64'(cpu_hold), 64'(vecs[v].hold));
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'(0));
            check($sformatf("vec%0d_wcnt", v), 64'(word_cnt), 64'(vecs[v].wcnt));
            check($sformatf("vec%0d_pending_writes", v), 64'(exp_q.size()), 64'(0));
        end

        // Framing error mid-word aborts without a write.
        send_seq(128'hA5021300, 4);
        check("fe_busy_before", 64'({busy, err}), 64'(2'b10));
        send_byte(8'h00, 1'b0);
        check("fe_err", 64'({busy, err, cpu_hold}), 64'(3'b011));
        check("fe_wcnt", 64'(word_cnt), 64'(0));

        // Loader switch dropped mid-frame.
        send_seq(128'hA50213, 3);
        load_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("load_en_fall_err", 64'({busy, err}), 64'(2'b01));
        load_en = 1'b1;
        repeat (4) @(negedge clk);

        // Inter-byte timeout.
        send_seq(128'hA503, 2);
        repeat (900) @(negedge clk);
        check("timeout_not_yet", 64'({busy, err}), 64'(2'b10));
        begin
            int waited = 0;
            while (!err && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            check("timeout_err", 64'(err), 64'(1));
        end

        // Reset after six data bytes: one write, then everything cleared.
        exp_q.push_back('{addr: 6'd0, data: 32'h00000013});
        send_seq(128'hA502130000009300, 8);
        check("midreset_one_write", 64'(exp_q.size()), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("midreset_outputs", 64'({im_we, cpu_hold, busy, done, err, word_cnt, im_addr}), 64'(0));
        check("midreset_wdata", 64'(im_wdata), 64'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        push_frame1();
        send_frame1();
        repeat (4) @(negedge clk);
        check("reload_done", 64'({done, err, cpu_hold, word_cnt}), 64'({3'b100, 7'd2}));
        check("reload_pending_writes", 64'(exp_q.size()), 64'(0));
        if (CHK_EN) check("done_after_checksum", 64'(done_rise_cyc - last_we_cyc > 100), 64'(1));
        else        check("done_cycle_after_write", 64'(done_rise_cyc - last_we_cyc), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
